// File: rtl/conv_integer_accum.sv
// Windowed accumulator behind the byte-to-integer conversion stage: sums, signed min/max
// over WINDOW samples, emitted as one record on a valid/ready output.
`timescale 1ns/1ps
module conv_integer_accum #(
  parameter int WINDOW = 4,
  parameter int ACC_W  = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_u,
  input  logic [31:0]      in_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sum_u,
  output logic [ACC_W-1:0] sum_i,
  output logic [31:0]      min_i,
  output logic [31:0]      max_i,
  output logic [15:0]      count
);

  typedef enum logic {ACCUM, FULL} state_t;

  localparam logic [15:0] LAST_IDX = 16'(WINDOW - 1);
  localparam logic [31:0] MIN_INIT = 32'h7FFF_FFFF;
  localparam logic [31:0] MAX_INIT = 32'h8000_0000;

  state_t           r_state;
  logic             r_outValid;
  logic [15:0]      r_sampCnt;
  logic [15:0]      r_count;
  logic [ACC_W-1:0] r_accU;
  logic [ACC_W-1:0] r_accI;
  logic [31:0]      r_min;
  logic [31:0]      r_max;
  logic [ACC_W-1:0] r_sumU;
  logic [ACC_W-1:0] r_sumI;
  logic [31:0]      r_minOut;
  logic [31:0]      r_maxOut;

  logic             w_inFire;
  logic             w_last;
  logic             w_emit;
  logic             w_accum;
  logic             w_outFire;
  logic [ACC_W-1:0] w_extU;
  logic [ACC_W-1:0] w_extI;
  logic [ACC_W-1:0] w_nextU;
  logic [ACC_W-1:0] w_nextI;
  logic [31:0]      w_nextMin;
  logic [31:0]      w_nextMax;

  // A pending record only blocks input when downstream is not taking it this cycle.
  assign in_ready  = !r_outValid || out_ready;
  assign w_inFire  = in_valid && in_ready;
  assign w_outFire = r_outValid && out_ready;
  assign w_last    = (r_sampCnt == LAST_IDX);
  assign w_emit    = w_inFire && w_last;
  assign w_accum   = w_inFire && !w_last;

  assign w_extU    = {{(ACC_W-32){1'b0}}, in_u};
  assign w_extI    = {{(ACC_W-32){in_i[31]}}, in_i};
  assign w_nextU   = r_accU + w_extU;
  assign w_nextI   = r_accI + w_extI;
  assign w_nextMin = ($signed(in_i) < $signed(r_min)) ? in_i : r_min;
  assign w_nextMax = ($signed(in_i) > $signed(r_max)) ? in_i : r_max;

  // In FULL the accumulators are already cleared, so an input accepted alongside the
  // output transfer naturally starts the next window (or re-emits when WINDOW is 1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ACCUM;
      r_outValid <= 1'b0;
      r_sampCnt  <= '0;
      r_count    <= '0;
      r_accU     <= '0;
      r_accI     <= '0;
      r_min      <= MIN_INIT;
      r_max      <= MAX_INIT;
      r_sumU     <= '0;
      r_sumI     <= '0;
      r_minOut   <= '0;
      r_maxOut   <= '0;
    end else begin
      case (r_state)
        ACCUM, FULL: begin
          if (w_emit) begin
            r_sumU     <= w_nextU;
            r_sumI     <= w_nextI;
            r_minOut   <= w_nextMin;
            r_maxOut   <= w_nextMax;
            r_outValid <= 1'b1;
            r_count    <= r_count + 16'd1;
            r_accU     <= '0;
            r_accI     <= '0;
            r_min      <= MIN_INIT;
            r_max      <= MAX_INIT;
            r_sampCnt  <= '0;
            r_state    <= FULL;
          end else begin
            if (w_accum) begin
              r_accU    <= w_nextU;
              r_accI    <= w_nextI;
              r_min     <= w_nextMin;
              r_max     <= w_nextMax;
              r_sampCnt <= r_sampCnt + 16'd1;
            end
            if (w_outFire) begin
              r_outValid <= 1'b0;
              r_state    <= ACCUM;
            end
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

  assign out_valid = r_outValid;
  assign sum_u     = r_sumU;
  assign sum_i     = r_sumI;
  assign min_i     = r_minOut;
  assign max_i     = r_maxOut;
  assign count     = r_count;

endmodule
